i2c_target: RTL

I2C_TARGET -- requirements
Module: i2c_target

---
 rtl/i2c_target.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/i2c_target.sv
// I2C target: 7-bit address match, register pointer, byte write strobe and optional read path.
// Define I2C_TARGET_READ_EN to enable read transfers; otherwise addressed reads are NACKed.
module i2c_target #(
  parameter logic [6:0]  DEV_ADDR    = 7'h39,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk_ref,
  input  logic       reset,
  input  logic       i2c_scl,
  inout  wire        i2c_sda,
  output logic       wr_valid,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       busy,
  output logic [3:0] states
);

`ifdef I2C_TARGET_READ_EN
  localparam bit ReadEn = 1'b1;
`else
  localparam bit ReadEn = 1'b0;
`endif

  typedef enum logic [3:0] {
    StIdle     = 4'd0,
    StDev      = 4'd1,
    StDevAck   = 4'd2,
    StReg      = 4'd3,
    StRegAck   = 4'd4,
    StWdata    = 4'd5,
    StWdataAck = 4'd6,
    StRdata    = 4'd7,
    StRdataAck = 4'd8,
    StIgnore   = 4'd9
  } state_e;

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_prev_q, sda_prev_q;
  logic                   scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] ptr_q, ptr_d;
  logic       rw_q, rw_d;
  logic       ack_q, ack_d;
  logic       oe_q, oe_d;
  logic       busy_q, busy_d;
  logic       wr_valid_q, wr_valid_d;
  logic [7:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  // SCL must be high on both samples so our own SDA changes after an SCL fall never qualify
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    ptr_d      = ptr_q;
    rw_d       = rw_q;
    ack_d      = ack_q;
    oe_d       = oe_q;
    busy_d     = busy_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    if (stop_det) begin
      state_d = StIdle;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
      cnt_d   = '0;
    end else if (start_det) begin
      state_d = StDev;
      oe_d    = 1'b0;
      cnt_d   = '0;
    end else begin
      if (scl_rise && (state_q inside {StDev, StReg, StWdata})) begin
        shift_d = {shift_q[6:0], sda_s};
        cnt_d   = cnt_q + 4'd1;
      end
      unique case (state_q)
        StDev: if (scl_fall && cnt_q == 4'd8) begin
          cnt_d = '0;
          rw_d  = shift_q[0];
          if (shift_q[7:1] == DEV_ADDR && (!shift_q[0] || ReadEn)) begin
            state_d = StDevAck;
            oe_d    = 1'b1;
            busy_d  = 1'b1;
          end else begin
            state_d = StIgnore;
          end
        end
        StDevAck: if (scl_fall) begin
          cnt_d = '0;
          oe_d  = 1'b0;
          if (rw_q && ReadEn) begin
            state_d = StRdata;
            shift_d = rd_data;
            oe_d    = ~rd_data[7];
          end else begin
            state_d = StReg;
          end
        end
        StReg: if (scl_fall && cnt_q == 4'd8) begin
          cnt_d   = '0;
          ptr_d   = shift_q;
          state_d = StRegAck;
          oe_d    = 1'b1;
        end
        StRegAck, StWdataAck: if (scl_fall) begin
          oe_d    = 1'b0;
          state_d = StWdata;
          cnt_d   = '0;
          if (state_q == StWdataAck) begin
            wr_valid_d = 1'b1;
            wr_addr_d  = ptr_q;
            wr_data_d  = shift_q;
            ptr_d      = ptr_q + 8'd1;
          end
        end
        StWdata: if (scl_fall && cnt_q == 4'd8) begin
          cnt_d   = '0;
          state_d = StWdataAck;
          oe_d    = 1'b1;
        end
        StRdata: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              cnt_d   = '0;
              oe_d    = 1'b0;
              state_d = StRdataAck;
            end else begin
              shift_d = {shift_q[6:0], 1'b1};
              oe_d    = ~shift_q[6];
            end
          end
        end
        StRdataAck: begin
          // Advance on the ACK rise so rd_data already reflects the new index at the fall
          if (scl_rise) begin
            ack_d = sda_s;
            if (!sda_s) ptr_d = ptr_q + 8'd1;
          end else if (scl_fall) begin
            if (!ack_q) begin
              state_d = StRdata;
              shift_d = rd_data;
              oe_d    = ~rd_data[7];
            end else begin
              state_d = StIgnore;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_ref) begin
    if (reset) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      state_q    <= StIdle;
      cnt_q      <= '0;
      shift_q    <= '0;
      ptr_q      <= '0;
      rw_q       <= 1'b0;
      ack_q      <= 1'b1;
      oe_q       <= 1'b0;
      busy_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], i2c_scl};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], i2c_sda};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      rw_q       <= rw_d;
      ack_q      <= ack_d;
      oe_q       <= oe_d;
      busy_q     <= busy_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign i2c_sda  = oe_q ? 1'b0 : 1'bz;
  assign wr_valid = wr_valid_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign rd_addr  = ptr_q;
  assign busy     = busy_q;
  assign states   = state_q;

endmodule
